regfile_access_ctrl: RTL

REGFILE_ACCESS_CTRL -- requirements
Module: regfile_access_ctrl

---
 rtl/regfile_access_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/regfile_access_ctrl.sv
// Register-file access sequencer. It serialises writebacks and operand fetches onto
// one register-file port set and hands the fetched operands to execute.
module regfile_access_ctrl #(
  parameter int DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 iss_valid_i,
  output logic                 iss_ready_o,
  input  logic [4:0]           rs1_addr_i,
  input  logic [4:0]           rs2_addr_i,
  input  logic                 rs1_en_i,
  input  logic                 rs2_en_i,
  output logic                 req_ra_o,
  output logic                 req_rb_o,
  output logic                 req_w_o,
  output logic [4:0]           raddr_a_o,
  output logic [4:0]           raddr_b_o,
  output logic [4:0]           waddr_a_o,
  input  logic [DataWidth-1:0] rdata_a_i,
  input  logic [DataWidth-1:0] rdata_b_i,
  output logic [DataWidth-1:0] wdata_a_o,
  input  logic                 wb_valid_i,
  output logic                 wb_ready_o,
  input  logic [4:0]           wb_addr_i,
  input  logic [DataWidth-1:0] wb_data_i,
  output logic                 op_valid_o,
  input  logic                 op_ready_i,
  output logic [DataWidth-1:0] op_a_o,
  output logic [DataWidth-1:0] op_b_o
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, CAPT, HOLD} state_e;

  state_e state_q, state_d;

  logic                 idle_q, idle_d;
  logic                 reqRa_q, reqRa_d, reqRb_q, reqRb_d, reqW_q, reqW_d;
  logic                 useA_q, useA_d, useB_q, useB_d;
  logic [4:0]           raddrA_q, raddrA_d, raddrB_q, raddrB_d, waddr_q, waddr_d;
  logic [DataWidth-1:0] wdata_q, wdata_d, opA_q, opA_d, opB_q, opB_d;
  logic                 opValid_q, opValid_d;
  logic                 wbAccept, issAccept;

  // idle_q stays low for the first cycle after reset so no handshake lands on the release edge
  assign wbAccept  = idle_q & wb_valid_i;
  assign issAccept = idle_q & ~wb_valid_i & iss_valid_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (wbAccept) state_d = WRITE;
               else if (issAccept) state_d = READ;
      WRITE:   state_d = IDLE;
      READ:    state_d = CAPT;
      CAPT:    state_d = HOLD;
      HOLD:    if (op_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    idle_d    = (state_d == IDLE);
    reqRa_d   = 1'b0;
    reqRb_d   = 1'b0;
    reqW_d    = 1'b0;
    useA_d    = useA_q;
    useB_d    = useB_q;
    raddrA_d  = raddrA_q;
    raddrB_d  = raddrB_q;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    opA_d     = opA_q;
    opB_d     = opB_q;
    opValid_d = opValid_q;
    case (state_q)
      IDLE: begin
        if (wbAccept) begin
          waddr_d = wb_addr_i;
          wdata_d = wb_data_i;
          reqW_d  = |wb_addr_i;
        end else if (issAccept) begin
          raddrA_d = rs1_addr_i;
          raddrB_d = rs2_addr_i;
          reqRa_d  = rs1_en_i & (|rs1_addr_i);
          reqRb_d  = rs2_en_i & (|rs2_addr_i);
          useA_d   = rs1_en_i & (|rs1_addr_i);
          useB_d   = rs2_en_i & (|rs2_addr_i);
        end
      end
      // x0 and unused operands read as zero without touching the register file
      CAPT: begin
        opA_d     = useA_q ? rdata_a_i : '0;
        opB_d     = useB_q ? rdata_b_i : '0;
        opValid_d = 1'b1;
      end
      HOLD: begin
        if (op_ready_i) opValid_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idle_q    <= 1'b0;
      reqRa_q   <= 1'b0;
      reqRb_q   <= 1'b0;
      reqW_q    <= 1'b0;
      useA_q    <= 1'b0;
      useB_q    <= 1'b0;
      raddrA_q  <= '0;
      raddrB_q  <= '0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      opA_q     <= '0;
      opB_q     <= '0;
      opValid_q <= 1'b0;
    end else begin
      idle_q    <= idle_d;
      reqRa_q   <= reqRa_d;
      reqRb_q   <= reqRb_d;
      reqW_q    <= reqW_d;
      useA_q    <= useA_d;
      useB_q    <= useB_d;
      raddrA_q  <= raddrA_d;
      raddrB_q  <= raddrB_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      opA_q     <= opA_d;
      opB_q     <= opB_d;
      opValid_q <= opValid_d;
    end
  end

  assign iss_ready_o = idle_q & ~wb_valid_i;
  assign wb_ready_o  = idle_q;
  assign req_ra_o    = reqRa_q;
  assign req_rb_o    = reqRb_q;
  assign req_w_o     = reqW_q;
  assign raddr_a_o   = raddrA_q;
  assign raddr_b_o   = raddrB_q;
  assign waddr_a_o   = waddr_q;
  assign wdata_a_o   = wdata_q;
  assign op_a_o      = opA_q;
  assign op_b_o      = opB_q;
  assign op_valid_o  = opValid_q;

endmodule
